arm7_bus_unit: RTL
==================

// Module: arm7_bus_unit
// PURPOSE
//   Parametrised bus interface unit between the ARM7TDMI core request port and a narrower,
//   wait-stated memory bus (e.g. 16-bit cartridge ROM/EWRAM). Splits CPU byte/half/word
//   accesses into MEM_W-wide beats and inserts a programmable wait-state count per beat
//   (non-sequential first beat, sequential following beats). Returns lane-placed read data
//   with a one-cycle acknowledge. Sits between the CPU core and the memory/region decoder.
// PARAMETERS
//   ADDR_W  32  address width (bytes)
//   DATA_W  32  CPU data width; multiple of MEM_W
//   MEM_W   16  memory bus width; 8, 16 or 32; must divide DATA_W
//   WS_W    4   wait-state counter width
// PORTS
//   clk        in   1              single clock
//   reset      in   1              asynchronous, active-high reset
//   cpu_req    in   1              access request, sampled only in IDLE
//   cpu_we     in   1              1 = write, 0 = read
//   cpu_size   in   2              0 = byte, 1 = half, 2/3 = word
//   cpu_seq    in   1              sequential hint: first beat uses cfg_ws_s
//   cpu_addr   in   ADDR_W         byte address
//   cpu_wdata  in   DATA_W         write data, lane-placed by addr[log2(DATA_W/8)-1:0]
//   cpu_rdata  out  DATA_W         read data, lane-placed; unaccessed lanes zero
//   cpu_ack    out  1              one-cycle completion pulse
//   cpu_busy   out  1              high in any state other than IDLE
//   cfg_ws_n   in   WS_W           non-sequential wait states
//   cfg_ws_s   in   WS_W           sequential wait states
//   mem_addr   out  ADDR_W         beat address, aligned to MEM_W/8 bytes
//   mem_wdata  out  MEM_W          beat write data
//   mem_rdata  in   MEM_W          beat read data, sampled at the end of XFER
//   mem_be     out  MEM_W/8        byte enables for the beat
//   mem_read   out  1              read strobe, high only in XFER with !we
//   mem_write  out  1              write strobe, high only in XFER with we
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; all outputs and capture registers are 0.
//     Strobes drop the same instant; an in-flight access is abandoned with no ack.
//   - States: IDLE, WAIT, XFER, ACK.
//   - IDLE with cpu_req=1: capture we/size/seq/addr/wdata.
//     - Address is force-aligned to the access size (half clears bit0, word clears bits[1:0]).
//     - Beats = max(1, bytes/(MEM_W/8)); the beat counter starts at 0.
//     - Clear the rdata accumulator.
//     - Load wait = cpu_seq ? cfg_ws_s : cfg_ws_n.
//     - Go to WAIT, or directly to XFER if the loaded wait count is 0.
//   - WAIT: decrement the counter each cycle; go to XFER on the cycle the counter reaches 1.
//   - XFER (exactly one cycle): assert mem_read or mem_write.
//     - mem_addr = aligned addr + beat*(MEM_W/8).
//     - mem_be = bytes of the access that fall in this beat.
//     - Read: merge mem_rdata into the matching DATA_W lanes.
//     - Not last beat: beat++, reload wait = cfg_ws_s, then WAIT or XFER as above.
//     - Last beat: go to ACK.
//   - ACK: cpu_ack=1 for exactly one cycle; cpu_rdata holds until the next access completes.
//     Next state is IDLE; a new request is accepted no earlier than the cycle after ACK.
//   - Latency from cycle of acceptance to ack cycle = 1 + sum over beats of (ws_beat + 1).
//   - cfg_ws_* are sampled when a wait count is loaded. Changes mid-beat have no effect on
//     that beat.
//   - cpu_req, cpu_addr and the other request inputs are ignored while busy.
//   - Sizes narrower than MEM_W take one beat with partial mem_be.
//   - mem_wdata = captured wdata lanes for the beat; disabled lanes drive 0.
//   - Beat address addition wraps modulo 2^ADDR_W.
// TESTING
//   1. Word read, MEM_W=16, ws_n=3, ws_s=1, addr=0x0800_0002
//      -> aligned to 0x0800_0000; beats at 0x0800_0000 then 0x0800_0002;
//         mem_rdata 0x1234 then 0xABCD -> cpu_rdata=0xABCD_1234; ack 7 cycles after accept.
//   2. Byte write, addr=0x0200_0003, wdata=0x5A00_0000, ws_n=0
//      -> one XFER with mem_addr=0x0200_0002, mem_be=2'b10, mem_wdata=0x5A00;
//         ack 2 cycles after accept.
//   3. Half read with cpu_seq=1, ws_s=2, ws_n=7 -> one beat after 2 wait cycles; ack 4 cycles after accept.
//   4. Assert reset during WAIT of beat 2 -> strobes low immediately, no ack, busy=0;
//      the next request completes normally.
//   5. Back-to-back: cpu_req held high through ACK -> second access accepted the cycle after ACK;
//      cpu_rdata stays stable between acks.
//   6. Address wrap: word access at 0xFFFF_FFFC, MEM_W=16 -> beats at 0xFFFF_FFFC and 0xFFFF_FFFE.

Source files
------------

// File: rtl/arm7_bus_unit.sv
// Bus interface unit: splits ARM7 core byte/half/word accesses into MEM_W-wide,
// wait-stated memory beats and returns lane-placed read data with a one-cycle ack.
module arm7_bus_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_W  = 16,
    parameter int WS_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [1:0]           cpu_size,
    input  logic                 cpu_seq,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_ack,
    output logic                 cpu_busy,
    input  logic [WS_W-1:0]      cfg_ws_n,
    input  logic [WS_W-1:0]      cfg_ws_s,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [MEM_W-1:0]     mem_wdata,
    input  logic [MEM_W-1:0]     mem_rdata,
    output logic [MEM_W/8-1:0]   mem_be,
    output logic                 mem_read,
    output logic                 mem_write
);
    localparam int MB  = MEM_W / 8;
    localparam int DB  = DATA_W / 8;
    localparam int MBL = $clog2(MB);
    localparam int DBL = $clog2(DB);
    localparam int NB  = DATA_W / MEM_W;
    localparam int BW  = $clog2(NB + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        ACK  = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                     input logic [1:0] sz);
        logic [ADDR_W-1:0] r;
        case (sz)
            2'd0:    r = a;
            2'd1:    r = {a[ADDR_W-1:1], 1'b0};
            default: r = {a[ADDR_W-1:2], 2'b00};
        endcase
        return r;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        int r;
        case (sz)
            2'd0:    r = 1;
            2'd1:    r = 2;
            default: r = 4;
        endcase
        return r;
    endfunction

    function automatic logic [BW-1:0] beat_count(input logic [1:0] sz);
        int n;
        n = size_bytes(sz) / MB;
        n = (n < 1) ? 1 : n;
        return BW'(n);
    endfunction

    // Beat address wraps modulo 2^ADDR_W and is forced onto a MEM_W boundary.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] al,
                                                    input logic [BW-1:0] bt);
        logic [ADDR_W-1:0] sum;
        sum = al + (ADDR_W'(bt) << MBL);
        return (sum >> MBL) << MBL;
    endfunction

    function automatic int lane_base(input logic [ADDR_W-1:0] ba);
        return int'(ba[DBL-1:0]);
    endfunction

    function automatic logic [MB-1:0] beat_be(input logic [ADDR_W-1:0] al,
                                              input logic [1:0] sz,
                                              input logic [ADDR_W-1:0] ba);
        logic [MB-1:0] be;
        int lo;
        int base;
        int nby;
        lo   = int'(al[DBL-1:0]);
        base = lane_base(ba);
        nby  = size_bytes(sz);
        for (int i = 0; i < MB; i++) begin
            be[i] = ((base + i) >= lo) && ((base + i) < (lo + nby));
        end
        return be;
    endfunction

    function automatic logic [MEM_W-1:0] byte_mask(input logic [MB-1:0] be);
        logic [MEM_W-1:0] m;
        for (int i = 0; i < MB; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [BW-1:0]       nbeats_q, nbeats_d;
    logic [WS_W-1:0]     wait_q, wait_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                cpu_busy_q, cpu_busy_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [MEM_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [MB-1:0]       mem_be_q, mem_be_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [DATA_W-1:0]   rd_lane_s;
    logic                xfer_s;

    // Next-state, capture and next-output computation.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        beat_d      = beat_q;
        nbeats_d    = nbeats_q;
        wait_d      = wait_q;
        cpu_rdata_d = cpu_rdata_q;
        rd_lane_s   = DATA_W'(mem_rdata & byte_mask(mem_be_q)) << (8 * lane_base(mem_addr_q));

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d     = cpu_we;
                    size_d   = cpu_size;
                    addr_d   = align_addr(cpu_addr, cpu_size);
                    wdata_d  = cpu_wdata;
                    acc_d    = {DATA_W{1'b0}};
                    beat_d   = {BW{1'b0}};
                    nbeats_d = beat_count(cpu_size);
                    wait_d   = cpu_seq ? cfg_ws_s : cfg_ws_n;
                    state_d  = (wait_d == {WS_W{1'b0}}) ? XFER : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                wait_d  = wait_q - WS_W'(1);
                state_d = (wait_q <= WS_W'(1)) ? XFER : WAIT;
            end
            XFER: begin
                if (!we_q) begin
                    acc_d = acc_q | rd_lane_s;
                end else begin
                    acc_d = acc_q;
                end
                if (beat_q == (nbeats_q - BW'(1))) begin
                    state_d     = ACK;
                    cpu_rdata_d = acc_d;
                end else begin
                    beat_d  = beat_q + BW'(1);
                    wait_d  = cfg_ws_s;
                    state_d = (cfg_ws_s == {WS_W{1'b0}}) ? XFER : WAIT;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the state being entered so they register cleanly.
        xfer_s      = (state_d == XFER);
        mem_read_d  = xfer_s && !we_d;
        mem_write_d = xfer_s && we_d;
        if (xfer_s) begin
            mem_addr_d  = beat_addr(addr_d, beat_d);
            mem_be_d    = beat_be(addr_d, size_d, mem_addr_d);
            mem_wdata_d = MEM_W'(wdata_d >> (8 * lane_base(mem_addr_d))) & byte_mask(mem_be_d);
        end else begin
            mem_addr_d  = {ADDR_W{1'b0}};
            mem_be_d    = {MB{1'b0}};
            mem_wdata_d = {MEM_W{1'b0}};
        end
        cpu_ack_d  = (state_d == ACK);
        cpu_busy_d = (state_d != IDLE);
    end

    // State, capture and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            acc_q       <= {DATA_W{1'b0}};
            beat_q      <= {BW{1'b0}};
            nbeats_q    <= {BW{1'b0}};
            wait_q      <= {WS_W{1'b0}};
            cpu_rdata_q <= {DATA_W{1'b0}};
            cpu_ack_q   <= 1'b0;
            cpu_busy_q  <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {MEM_W{1'b0}};
            mem_be_q    <= {MB{1'b0}};
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            nbeats_q    <= nbeats_d;
            wait_q      <= wait_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_busy_q  <= cpu_busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_busy  = cpu_busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule
